// File: rtl/uart_cmd_ctrl_if.sv
// Interface bundling the UART receive strobe, register request/ack bus and
// transmit valid/ready handshake used by uart_cmd_ctrl.
//   master : the command controller (drives o_* signals)
//   slave  : the surrounding UART and register map (drives i_* signals)
// Signal names follow the controller's point of view.
interface uart_cmd_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  i_rx_dv;
    logic [7:0]            i_rx_byte;
    logic                  i_rx_error;
    logic                  o_reg_wr;
    logic                  o_reg_rd;
    logic [ADDR_WIDTH-1:0] o_reg_addr;
    logic [7:0]            o_reg_wdata;
    logic [7:0]            i_reg_rdata;
    logic                  i_reg_ack;
    logic                  o_tx_valid;
    logic [7:0]            o_tx_byte;
    logic                  i_tx_ready;

    modport master (
        input  i_rx_dv, i_rx_byte, i_rx_error, i_reg_rdata, i_reg_ack, i_tx_ready,
        output o_reg_wr, o_reg_rd, o_reg_addr, o_reg_wdata, o_tx_valid, o_tx_byte
    );

    modport slave (
        output i_rx_dv, i_rx_byte, i_rx_error, i_reg_rdata, i_reg_ack, i_tx_ready,
        input  o_reg_wr, o_reg_rd, o_reg_addr, o_reg_wdata, o_tx_valid, o_tx_byte
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command controller. Parses 5-byte frames (SYNC, CMD, ADDR, DATA, CHK)
// from the UART receiver, performs a register write (CMD 01) or read (CMD 02)
// on the request/ack bus and returns a 2-byte response (status, rdata).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   io_bus         : rx strobe/byte/error, register bus, tx handshake
//   o_busy         : high whenever the FSM is not hunting for SYNC
//   o_err_cnt      : saturating count of error events
module uart_cmd_ctrl #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned BYTE_TIMEOUT = 50000,
    parameter int unsigned ACK_TIMEOUT  = 1024,
    parameter int unsigned ADDR_WIDTH   = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    uart_cmd_ctrl_if.master        io_bus,
    output logic                   o_busy,
    output logic [7:0]             o_err_cnt
);

    localparam int unsigned BT_W = (BYTE_TIMEOUT > 2) ? $clog2(BYTE_TIMEOUT) : 1;
    localparam int unsigned AT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TIMEOUT - 1);
    localparam logic [AT_W-1:0] AT_LAST = AT_W'(ACK_TIMEOUT - 1);

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;
    localparam logic [7:0] ST_ACK = 8'h06;
    localparam logic [7:0] ST_NAK = 8'h15;

    typedef enum logic [3:0] {
        StHunt, StGetCmd, StGetAddr, StGetData, StGetChk,
        StExec, StWaitAck, StRespStat, StRespData
    } state_e;

    state_e                r_state;
    logic [7:0]            r_cmd, r_addr, r_data, r_chk;
    logic [7:0]            r_rdata;
    logic [BT_W-1:0]       r_byte_tmr;
    logic [AT_W-1:0]       r_ack_tmr;
    logic                  r_rx_err_q;
    logic [7:0]            r_err_cnt;
    logic                  r_reg_wr, r_reg_rd;
    logic [ADDR_WIDTH-1:0] r_reg_addr;
    logic [7:0]            r_reg_wdata;
    logic                  r_tx_valid;
    logic [7:0]            r_tx_byte;

    logic w_rx_rise, w_get, w_byte_to, w_ack_to, w_bad, w_tx_hs, w_err_evt;

    assign w_rx_rise = io_bus.i_rx_error & ~r_rx_err_q;
    assign w_get     = (r_state == StGetCmd) || (r_state == StGetAddr) ||
                       (r_state == StGetData) || (r_state == StGetChk);
    assign w_byte_to = (r_byte_tmr == BT_LAST);
    assign w_ack_to  = (r_ack_tmr == AT_LAST);
    assign w_bad     = ((r_cmd ^ r_addr ^ r_data) != r_chk) ||
                       ((r_cmd != CMD_WR) && (r_cmd != CMD_RD));
    assign w_tx_hs   = r_tx_valid & io_bus.i_tx_ready;

    // All error sources OR together so coincident events count once.
    always_comb begin
        w_err_evt = w_rx_rise;
        unique case (r_state)
            StGetCmd, StGetAddr, StGetData, StGetChk:
                if (!io_bus.i_rx_dv && w_byte_to) w_err_evt = 1'b1;
            StExec:
                if (io_bus.i_rx_dv || w_bad) w_err_evt = 1'b1;
            StWaitAck:
                if (io_bus.i_rx_dv || (!io_bus.i_reg_ack && w_ack_to)) w_err_evt = 1'b1;
            StRespStat, StRespData:
                if (io_bus.i_rx_dv) w_err_evt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StHunt;
            r_cmd       <= 8'h00;
            r_addr      <= 8'h00;
            r_data      <= 8'h00;
            r_chk       <= 8'h00;
            r_rdata     <= 8'h00;
            r_byte_tmr  <= '0;
            r_ack_tmr   <= '0;
            r_rx_err_q  <= 1'b0;
            r_err_cnt   <= 8'h00;
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_tx_byte   <= 8'h00;
        end else begin
            r_rx_err_q <= io_bus.i_rx_error;
            if (w_err_evt && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;

            // Cleared in HUNT so it starts from zero on entry to GET_CMD.
            if (io_bus.i_rx_dv || !w_get) r_byte_tmr <= '0;
            else                          r_byte_tmr <= r_byte_tmr + 1'b1;

            if (r_state == StWaitAck) r_ack_tmr <= r_ack_tmr + 1'b1;
            else                      r_ack_tmr <= '0;

            unique case (r_state)
                StHunt: begin
                    if (io_bus.i_rx_dv && (io_bus.i_rx_byte == SYNC_BYTE)) r_state <= StGetCmd;
                end
                StGetCmd, StGetAddr, StGetData, StGetChk: begin
                    if (w_rx_rise) begin
                        r_state <= StHunt;
                    end else if (io_bus.i_rx_dv) begin
                        unique case (r_state)
                            StGetCmd:  begin r_cmd  <= io_bus.i_rx_byte; r_state <= StGetAddr; end
                            StGetAddr: begin r_addr <= io_bus.i_rx_byte; r_state <= StGetData; end
                            StGetData: begin r_data <= io_bus.i_rx_byte; r_state <= StGetChk;  end
                            default:   begin r_chk  <= io_bus.i_rx_byte; r_state <= StExec;    end
                        endcase
                    end else if (w_byte_to) begin
                        r_state <= StHunt;
                    end
                end
                StExec: begin
                    if (w_bad) begin
                        r_rdata    <= 8'h00;
                        r_tx_valid <= 1'b1;
                        r_tx_byte  <= ST_NAK;
                        r_state    <= StRespStat;
                    end else begin
                        r_reg_wr    <= (r_cmd == CMD_WR);
                        r_reg_rd    <= (r_cmd == CMD_RD);
                        r_reg_addr  <= r_addr[ADDR_WIDTH-1:0];
                        r_reg_wdata <= r_data;
                        r_state     <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (io_bus.i_reg_ack) begin
                        r_reg_wr   <= 1'b0;
                        r_reg_rd   <= 1'b0;
                        r_rdata    <= r_reg_rd ? io_bus.i_reg_rdata : 8'h00;
                        r_tx_valid <= 1'b1;
                        r_tx_byte  <= ST_ACK;
                        r_state    <= StRespStat;
                    end else if (w_ack_to) begin
                        r_reg_wr   <= 1'b0;
                        r_reg_rd   <= 1'b0;
                        r_rdata    <= 8'h00;
                        r_tx_valid <= 1'b1;
                        r_tx_byte  <= ST_NAK;
                        r_state    <= StRespStat;
                    end
                end
                StRespStat: begin
                    if (w_tx_hs) begin
                        r_tx_byte <= r_rdata;
                        r_state   <= StRespData;
                    end
                end
                StRespData: begin
                    if (w_tx_hs) begin
                        r_tx_valid <= 1'b0;
                        r_tx_byte  <= 8'h00;
                        r_state    <= StHunt;
                    end
                end
                default: r_state <= StHunt;
            endcase
        end
    end

    assign io_bus.o_reg_wr    = r_reg_wr;
    assign io_bus.o_reg_rd    = r_reg_rd;
    assign io_bus.o_reg_addr  = r_reg_addr;
    assign io_bus.o_reg_wdata = r_reg_wdata;
    assign io_bus.o_tx_valid  = r_tx_valid;
    assign io_bus.o_tx_byte   = r_tx_byte;
    assign o_busy             = (r_state != StHunt);
    assign o_err_cnt          = r_err_cnt;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed testbench for uart_cmd_ctrl with short timeouts (byte 100, ack 16).
module tb_uart_cmd_ctrl;

    localparam int unsigned AW = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    uart_cmd_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    uart_cmd_ctrl #(
        .SYNC_BYTE    (8'hA5),
        .BYTE_TIMEOUT (100),
        .ACK_TIMEOUT  (16),
        .ADDR_WIDTH   (AW)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .io_bus    (bus),
        .o_busy    (busy),
        .o_err_cnt (err_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one byte for one clock; returns at the negedge after capture.
    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_dv   = 1'b1;
        bus.i_rx_byte = b;
        @(negedge clk);
        bus.i_rx_dv   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, addr, data, chk);
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(addr);
        send_byte(data);
        send_byte(chk);
    endtask

    // Entered right after the CHK byte (FSM in EXEC). ack_at = 0 means never ack.
    task automatic access(input string tag, input logic is_wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input int ack_at, input logic [7:0] rdata);
        logic [1:0] exp_req;
        int         hold_bad;
        int         hi;
        exp_req  = is_wr ? 2'b10 : 2'b01;
        hold_bad = 0;
        check_eq({tag, "_lat_exec"}, {30'd0, bus.o_reg_wr, bus.o_reg_rd}, 32'd0);
        @(negedge clk);
        check_eq({tag, "_req"}, {30'd0, bus.o_reg_wr, bus.o_reg_rd}, {30'd0, exp_req});
        check_eq({tag, "_addr"}, {24'd0, bus.o_reg_addr}, {24'd0, addr});
        if (is_wr) check_eq({tag, "_wdata"}, {24'd0, bus.o_reg_wdata}, {24'd0, wdata});
        if (ack_at > 0) begin
            repeat (ack_at - 1) begin
                @(negedge clk);
                if ({bus.o_reg_wr, bus.o_reg_rd} !== exp_req || bus.o_reg_addr !== addr)
                    hold_bad++;
            end
            check_eq({tag, "_hold"}, hold_bad, 32'd0);
            bus.i_reg_ack   = 1'b1;
            bus.i_reg_rdata = rdata;
            @(negedge clk);
            bus.i_reg_ack   = 1'b0;
            bus.i_reg_rdata = 8'h00;
            check_eq({tag, "_drop"}, {30'd0, bus.o_reg_wr, bus.o_reg_rd}, 32'd0);
        end else begin
            hi = 1;
            while ((bus.o_reg_wr || bus.o_reg_rd) && hi < 100) begin
                @(negedge clk);
                if (bus.o_reg_wr || bus.o_reg_rd) hi++;
            end
            check_eq({tag, "_req_cycles"}, hi, 32'd16);
        end
    endtask

    // Collect the two response bytes, optionally stalling i_tx_ready first.
    task automatic resp(input string tag, input logic [7:0] stat, input logic [7:0] data,
                        input int stall);
        int w;
        int bad;
        w   = 0;
        bad = 0;
        while (!bus.o_tx_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq({tag, "_valid"}, {31'd0, bus.o_tx_valid}, 32'd1);
        check_eq({tag, "_stat"}, {24'd0, bus.o_tx_byte}, {24'd0, stat});
        repeat (stall) begin
            @(negedge clk);
            if (!bus.o_tx_valid || bus.o_tx_byte !== stat) bad++;
        end
        if (stall > 0) check_eq({tag, "_stall"}, bad, 32'd0);
        bus.i_tx_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, "_data_valid"}, {31'd0, bus.o_tx_valid}, 32'd1);
        check_eq({tag, "_data"}, {24'd0, bus.o_tx_byte}, {24'd0, data});
        @(negedge clk);
        bus.i_tx_ready = 1'b0;
        check_eq({tag, "_done"}, {30'd0, bus.o_tx_valid, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        bus.i_rx_dv     = 1'b0;
        bus.i_rx_byte   = 8'h00;
        bus.i_rx_error  = 1'b0;
        bus.i_reg_rdata = 8'h00;
        bus.i_reg_ack   = 1'b0;
        bus.i_tx_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", {bus.o_reg_wr, bus.o_reg_rd, bus.o_reg_addr, bus.o_reg_wdata,
                                 bus.o_tx_valid, bus.o_tx_byte}, 32'd0);
        check_eq("rst_status", {23'd0, busy, err_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write, ack on the third request cycle.
        send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
        access("wr", 1'b1, 8'h10, 8'h3C, 3, 8'h00);
        resp("wr", 8'h06, 8'h00, 0);
        check_eq("wr_err", {24'd0, err_cnt}, 32'd0);

        // Read with a 10-cycle transmitter stall.
        send_frame(8'h02, 8'h22, 8'h00, 8'h20);
        access("rd", 1'b0, 8'h22, 8'h00, 1, 8'h5A);
        resp("rd", 8'h06, 8'h5A, 10);
        check_eq("rd_err", {24'd0, err_cnt}, 32'd0);

        // Garbage before SYNC, then bad checksum.
        send_byte(8'h00);
        send_byte(8'hFF);
        check_eq("garbage", {23'd0, busy, err_cnt}, 32'd0);
        send_frame(8'h01, 8'h10, 8'h3C, 8'h00);
        check_eq("badchk_exec", {30'd0, bus.o_reg_wr, bus.o_reg_rd}, 32'd0);
        @(negedge clk);
        check_eq("badchk_nobus", {30'd0, bus.o_reg_wr, bus.o_reg_rd}, 32'd0);
        resp("badchk", 8'h15, 8'h00, 0);
        check_eq("badchk_err", {24'd0, err_cnt}, 32'd1);

        // Partial frame abandoned after 100 idle clocks.
        send_byte(8'hA5);
        send_byte(8'h01);
        cyc = 0;
        while (busy && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("byte_to_cycles", cyc, 32'd100);
        check_eq("byte_to_err", {24'd0, err_cnt}, 32'd2);
        send_frame(8'h01, 8'h33, 8'h44, 8'h76);
        access("wr2", 1'b1, 8'h33, 8'h44, 2, 8'h00);
        resp("wr2", 8'h06, 8'h00, 0);
        check_eq("wr2_err", {24'd0, err_cnt}, 32'd2);

        // No ack: request drops after 16 cycles.
        send_frame(8'h02, 8'h40, 8'h00, 8'h42);
        access("ackto", 1'b0, 8'h40, 8'h00, 0, 8'h00);
        resp("ackto", 8'h15, 8'h00, 0);
        check_eq("ackto_err", {24'd0, err_cnt}, 32'd3);

        // Framing error during GET_ADDR, held two cycles: counts once.
        send_byte(8'hA5);
        send_byte(8'h01);
        bus.i_rx_error = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rxerr_hunt", {23'd0, busy, err_cnt}, {23'd0, 1'b0, 8'd4});
        bus.i_rx_error = 1'b0;
        @(negedge clk);

        // Reset during WAIT_ACK.
        send_frame(8'h01, 8'h55, 8'h66, 8'h32);
        @(negedge clk);
        check_eq("pre_rst_req", {31'd0, bus.o_reg_wr}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_outputs", {bus.o_reg_wr, bus.o_reg_rd, bus.o_reg_addr,
                                     bus.o_reg_wdata, bus.o_tx_valid, bus.o_tx_byte}, 32'd0);
        check_eq("mid_rst_status", {23'd0, busy, err_cnt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Recovery read.
        send_frame(8'h02, 8'h7F, 8'h00, 8'h7D);
        access("rd2", 1'b0, 8'h7F, 8'h00, 2, 8'hC3);
        resp("rd2", 8'h06, 8'hC3, 0);
        check_eq("rd2_err", {24'd0, err_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1);
    end

endmodule
